// File: rtl/rotor_step_ctrl.sv
// rotor_step_ctrl: turns key events into rotor step pulses and letter strobes, plus config-mode rotor editing.
// Ports: clk, reset (sync, active-high); key_ready/make/ext/key_input key event; shift0..2 rotor positions;
//        increase0..2 step pulses, increase_shift_or_type target level, letter_valid/letter encoded letter,
//        config_mode, rotor_sel, busy, dropped (sticky). Macro DOUBLE_STEP_EN enables the double-step anomaly.
module rotor_step_ctrl #(
    parameter logic [4:0] NOTCH0 = 5'd16,
    parameter logic [4:0] NOTCH1 = 5'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_ready,
    input  logic       make,
    input  logic       ext,
    input  logic [7:0] key_input,
    input  logic [4:0] shift0,
    input  logic [4:0] shift1,
    input  logic [4:0] shift2,
    output logic       increase0,
    output logic       increase1,
    output logic       increase2,
    output logic       increase_shift_or_type,
    output logic       letter_valid,
    output logic [4:0] letter,
    output logic       config_mode,
    output logic [1:0] rotor_sel,
    output logic       busy,
    output logic       dropped
);
    typedef enum logic [1:0] {IDLE, STEP, SETTLE, EMIT} state_t;
    state_t state, state_next;
    logic       ev, idle_ev, cfg_ev, letter_go, type_bit, hit1, shift2_unused;
    logic [2:0] cfg_inc;
    logic [7:0] off;
    assign ev        = key_ready & make;
    assign idle_ev   = ev & (state == IDLE);
    assign cfg_ev    = idle_ev & config_mode;
    assign letter_go = idle_ev & ~config_mode & ~ext & (key_input >= 8'h41) & (key_input <= 8'h5A);
    assign off       = key_input - 8'h41;
    assign busy      = state != IDLE;
    // Rotor 2's position never influences stepping; the odometer only looks at the lower two rotors.
    assign shift2_unused = ^shift2;
`ifdef DOUBLE_STEP_EN
    // Rotor 1 sitting on its own notch drags itself along with rotor 2.
    assign hit1 = (shift0 == NOTCH0) | (shift1 == NOTCH1);
`else
    assign hit1 = shift0 == NOTCH0;
`endif
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end
    always_comb begin
        state_next             = state;
        increase0              = cfg_inc[0];
        increase1              = cfg_inc[1];
        increase2              = cfg_inc[2];
        letter_valid           = 1'b0;
        increase_shift_or_type = config_mode & type_bit;
        case (state)
            IDLE: state_next = letter_go ? STEP : IDLE;
            STEP: begin
                increase0              = 1'b1;
                increase1              = hit1;
                increase2              = shift1 == NOTCH1;
                increase_shift_or_type = 1'b0;
                state_next             = SETTLE;
            end
            SETTLE: state_next = EMIT;
            default: begin
                letter_valid = 1'b1;
                state_next   = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            letter      <= '0;
            config_mode <= 1'b0;
            rotor_sel   <= '0;
            type_bit    <= 1'b0;
            dropped     <= 1'b0;
            cfg_inc     <= '0;
        end else begin
            cfg_inc <= (cfg_ev && ext && key_input == 8'h75) ? 3'b001 << rotor_sel : 3'b000;
            if (idle_ev && ext && key_input == 8'h5A) config_mode <= ~config_mode;
            if (letter_go) letter <= off[4:0];
            if (cfg_ev && ext && key_input == 8'h6B) rotor_sel <= (rotor_sel == 2'd0) ? 2'd2 : rotor_sel - 2'd1;
            if (cfg_ev && ext && key_input == 8'h74) rotor_sel <= (rotor_sel == 2'd2) ? 2'd0 : rotor_sel + 2'd1;
            if (cfg_ev && !ext && key_input == 8'h54) type_bit <= ~type_bit;
            if (ev && busy) dropped <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rotor_step_ctrl.sv
// tb_rotor_step_ctrl: directed self-checking bench for rotor_step_ctrl.
module tb_rotor_step_ctrl;
    logic       clk = 1'b0, reset = 1'b1, key_ready = 1'b0, make = 1'b0, ext = 1'b0;
    logic [7:0] key_input = 8'h00;
    logic [4:0] shift0 = 5'd0, shift1 = 5'd0, shift2 = 5'd0;
    logic       increase0, increase1, increase2, increase_shift_or_type, letter_valid, config_mode, busy, dropped;
    logic [4:0] letter;
    logic [1:0] rotor_sel;
    logic [2:0] incs;
    int checks = 0, errors = 0;
    assign incs = {increase2, increase1, increase0};
    always #5 clk = ~clk;
    rotor_step_ctrl dut (
        .clk(clk), .reset(reset), .key_ready(key_ready), .make(make), .ext(ext), .key_input(key_input),
        .shift0(shift0), .shift1(shift1), .shift2(shift2),
        .increase0(increase0), .increase1(increase1), .increase2(increase2),
        .increase_shift_or_type(increase_shift_or_type), .letter_valid(letter_valid), .letter(letter),
        .config_mode(config_mode), .rotor_sel(rotor_sel), .busy(busy), .dropped(dropped)
    );
    // Presents one event for a single cycle; returns at the sample point of cycle N+1.
    task automatic send(input logic m, input logic e, input logic [7:0] k);
        @(negedge clk);
        key_ready = 1'b1; make = m; ext = e; key_input = k;
        @(negedge clk);
        key_ready = 1'b0; make = 1'b0; ext = 1'b0;
    endtask
    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({incs, letter_valid, letter, config_mode, rotor_sel, busy, dropped, increase_shift_or_type} !== 15'd0) begin
            errors++;
            $display("FAIL reset_state: got incs=%b lv=%b letter=%0d cfg=%b sel=%0d busy=%b drop=%b isot=%b, want all 0",
                     incs, letter_valid, letter, config_mode, rotor_sel, busy, dropped, increase_shift_or_type);
        end
    endtask
    task automatic test_letter(input string name, input logic [4:0] s0, input logic [4:0] s1,
                               input logic [7:0] k, input logic [2:0] exp_inc, input logic [4:0] exp_letter);
        shift0 = s0; shift1 = s1; shift2 = 5'd7;
        send(1'b1, 1'b0, k);
        checks++;
        if ({incs, letter_valid, busy} !== {exp_inc, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL %s_step: got incs=%b lv=%b busy=%b, want incs=%b lv=0 busy=1", name, incs, letter_valid, busy, exp_inc);
        end
        @(negedge clk);
        checks++;
        if ({incs, letter_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL %s_settle: got incs=%b lv=%b, want 000/0", name, incs, letter_valid);
        end
        @(negedge clk);
        checks++;
        if ({incs, letter_valid, letter} !== {4'b0001, exp_letter}) begin
            errors++;
            $display("FAIL %s_emit: got incs=%b lv=%b letter=%0d, want 000/1 letter=%0d", name, incs, letter_valid, letter, exp_letter);
        end
        @(negedge clk);
        checks++;
        if ({busy, letter_valid} !== 2'b00) begin
            errors++;
            $display("FAIL %s_idle: got busy=%b lv=%b, want 0/0", name, busy, letter_valid);
        end
    endtask
    task automatic test_back_to_back;
        shift0 = 5'd0; shift1 = 5'd0;
        send(1'b1, 1'b0, 8'h41);
        key_ready = 1'b1; make = 1'b1; key_input = 8'h42;
        @(negedge clk);
        key_ready = 1'b0; make = 1'b0;
        checks++;
        if ({dropped, incs} !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_dropped: got dropped=%b incs=%b, want 1/000", dropped, incs);
        end
        @(negedge clk);
        checks++;
        if ({letter_valid, letter} !== {1'b1, 5'd0}) begin
            errors++;
            $display("FAIL b2b_letter: got lv=%b letter=%0d, want 1/0", letter_valid, letter);
        end
        send(1'b1, 1'b0, 8'h47);
        checks++;
        if ({incs, busy} !== 4'b0011) begin
            errors++;
            $display("FAIL b2b_g_step: got incs=%b busy=%b, want 001/1", incs, busy);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({letter_valid, letter, dropped} !== {1'b1, 5'd6, 1'b1}) begin
            errors++;
            $display("FAIL b2b_g_letter: got lv=%b letter=%0d dropped=%b, want 1/6/1", letter_valid, letter, dropped);
        end
        @(negedge clk);
    endtask
    task automatic test_config;
        send(1'b1, 1'b1, 8'h5A);
        checks++;
        if ({config_mode, busy, rotor_sel} !== 4'b1000) begin
            errors++;
            $display("FAIL cfg_enter: got cfg=%b busy=%b sel=%0d, want 1/0/0", config_mode, busy, rotor_sel);
        end
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 1'b1, 8'h74);
            checks++;
            if (rotor_sel !== 2'((i + 1) % 3)) begin
                errors++;
                $display("FAIL cfg_right%0d: got sel=%0d, want %0d", i, rotor_sel, (i + 1) % 3);
            end
        end
        send(1'b1, 1'b0, 8'h54);
        checks++;
        if (increase_shift_or_type !== 1'b1) begin
            errors++;
            $display("FAIL cfg_type: got isot=%b, want 1", increase_shift_or_type);
        end
        send(1'b1, 1'b1, 8'h75);
        checks++;
        if (incs !== 3'b001) begin
            errors++;
            $display("FAIL cfg_up0: got incs=%b, want 001", incs);
        end
        @(negedge clk);
        checks++;
        if (incs !== 3'b000) begin
            errors++;
            $display("FAIL cfg_up0_once: got incs=%b, want 000", incs);
        end
        send(1'b1, 1'b1, 8'h6B);
        checks++;
        if (rotor_sel !== 2'd2) begin
            errors++;
            $display("FAIL cfg_left_wrap: got sel=%0d, want 2", rotor_sel);
        end
        send(1'b1, 1'b1, 8'h75);
        checks++;
        if (incs !== 3'b100) begin
            errors++;
            $display("FAIL cfg_up2: got incs=%b, want 100", incs);
        end
        send(1'b1, 1'b0, 8'h41);
        checks++;
        if ({busy, incs, letter_valid, rotor_sel} !== {5'b00000, 2'd2}) begin
            errors++;
            $display("FAIL cfg_letter_ignored: got busy=%b incs=%b lv=%b sel=%0d, want 0/000/0/2", busy, incs, letter_valid, rotor_sel);
        end
        send(1'b1, 1'b1, 8'h5A);
        checks++;
        if ({config_mode, increase_shift_or_type} !== 2'b00) begin
            errors++;
            $display("FAIL cfg_exit: got cfg=%b isot=%b, want 0/0", config_mode, increase_shift_or_type);
        end
    endtask
    task automatic test_reset_mid;
        shift0 = 5'd16; shift1 = 5'd4;
        send(1'b1, 1'b0, 8'h45);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({incs, letter_valid, letter, config_mode, rotor_sel, busy, dropped} !== 14'd0) begin
            errors++;
            $display("FAIL reset_mid: got incs=%b lv=%b letter=%0d cfg=%b sel=%0d busy=%b drop=%b, want all 0",
                     incs, letter_valid, letter, config_mode, rotor_sel, busy, dropped);
        end
        @(negedge clk);
        checks++;
        if ({incs, letter_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_quiet: got incs=%b lv=%b, want 000/0", incs, letter_valid);
        end
        shift0 = 5'd0; shift1 = 5'd0;
        send(1'b0, 1'b0, 8'h41);
        checks++;
        if ({busy, incs} !== 4'b0000) begin
            errors++;
            $display("FAIL break_code: got busy=%b incs=%b, want 0/000", busy, incs);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({letter_valid, letter} !== 6'd0) begin
            errors++;
            $display("FAIL break_code_lv: got lv=%b letter=%0d, want 0/0", letter_valid, letter);
        end
    endtask
    initial begin
        test_reset();
        test_letter("key_a", 5'd0, 5'd0, 8'h41, 3'b001, 5'd0);
        test_letter("key_c_notch", 5'd16, 5'd3, 8'h43, 3'b011, 5'd2);
`ifdef DOUBLE_STEP_EN
        test_letter("key_d_double", 5'd2, 5'd4, 8'h44, 3'b111, 5'd3);
`else
        test_letter("key_d_double", 5'd2, 5'd4, 8'h44, 3'b101, 5'd3);
`endif
        test_letter("key_z", 5'd16, 5'd4, 8'h5A, 3'b111, 5'd25);
        test_back_to_back();
        test_config();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
